// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word per req/ready handshake,
// predicts the next PC from a 2-bit BHT plus JAL decode and presents it to IF/ID.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall,
    input  logic        branch_error,
    input  logic [31:0] redirect_pc,
    input  logic        bht_we,
    input  logic [31:0] bht_pc,
    input  logic        bht_taken,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_inst_i,
    output logic        stallreq_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        predict_result_o,
    output logic [31:0] next_pc_o
);

    localparam int unsigned BhtDepth   = 2 ** BHT_IDX_W;
    localparam logic [1:0]  StallPass  = 2'b00;
    localparam logic [6:0]  OpJal      = 7'b1101111;
    localparam logic [6:0]  OpBranch   = 7'b1100011;

    typedef enum logic [1:0] {StFetch, StHave, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [1:0]  bht_q [BhtDepth];

    logic [BHT_IDX_W-1:0] lookup_idx, update_idx;
    logic [31:0]          j_imm, b_imm, pred_next_pc;
    logic                 pred_taken;
    logic                 unused_bht_pc;

    assign lookup_idx    = pc_q[BHT_IDX_W+1:2];
    assign update_idx    = bht_pc[BHT_IDX_W+1:2];
    assign unused_bht_pc = ^{bht_pc[31:BHT_IDX_W+2], bht_pc[1:0]};

    assign j_imm = {{12{inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
    assign b_imm = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};

    always_comb begin
        pred_taken   = 1'b0;
        pred_next_pc = pc_q + 32'd4;
        if (inst_q[6:0] == OpJal) begin
            pred_taken   = 1'b1;
            pred_next_pc = pc_q + j_imm;
        end else if (inst_q[6:0] == OpBranch && bht_q[lookup_idx][1]) begin
            pred_taken   = 1'b1;
            pred_next_pc = pc_q + b_imm;
        end
    end

    // branch_error beats stall and ready; in DRAIN it only retargets the PC.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        drain_addr_d = drain_addr_q;
        case (state_q)
            StFetch: begin
                if (branch_error) begin
                    pc_d = redirect_pc;
                    if (!mem_ready_i) begin
                        state_d      = StDrain;
                        drain_addr_d = pc_q;
                    end
                end else if (mem_ready_i) begin
                    inst_d  = mem_inst_i;
                    state_d = StHave;
                end
            end
            StHave: begin
                if (branch_error) begin
                    pc_d    = redirect_pc;
                    state_d = StFetch;
                end else if (stall == StallPass) begin
                    pc_d    = pred_next_pc;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (branch_error) pc_d = redirect_pc;
                if (mem_ready_i) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0;
            drain_addr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bht_q <= '{default: 2'b01};
        end else if (bht_we) begin
            if (bht_taken && bht_q[update_idx] != 2'b11) begin
                bht_q[update_idx] <= bht_q[update_idx] + 2'd1;
            end else if (!bht_taken && bht_q[update_idx] != 2'b00) begin
                bht_q[update_idx] <= bht_q[update_idx] - 2'd1;
            end
        end
    end

    // Outputs depend on registers and rst only, never on the mem_* inputs.
    always_comb begin
        mem_req_o        = 1'b0;
        mem_addr_o       = 32'h0;
        stallreq_o       = 1'b0;
        pc_o             = 32'h0;
        inst_o           = 32'h0;
        predict_result_o = 1'b0;
        next_pc_o        = 32'h0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = pc_q;
                    stallreq_o = 1'b1;
                end
                StDrain: begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = drain_addr_q;
                    stallreq_o = 1'b1;
                end
                StHave: begin
                    pc_o             = pc_q;
                    inst_o           = inst_q;
                    predict_result_o = pred_taken;
                    next_pc_o        = pred_next_pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic, every cycle compared
// against a transaction-level reference model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] RstPc = 32'h100;
    localparam logic [1:0]  Pass  = 2'b00;
    localparam logic [1:0]  Hold  = 2'b01;
    localparam logic [1:0]  Bubb  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stall;
    logic        branch_error;
    logic [31:0] redirect_pc;
    logic        bht_we;
    logic [31:0] bht_pc;
    logic        bht_taken;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_inst_i;
    logic        stallreq_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        predict_result_o;
    logic [31:0] next_pc_o;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC  (RstPc),
        .BHT_IDX_W (6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .branch_error     (branch_error),
        .redirect_pc      (redirect_pc),
        .bht_we           (bht_we),
        .bht_pc           (bht_pc),
        .bht_taken        (bht_taken),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ready_i      (mem_ready_i),
        .mem_inst_i       (mem_inst_i),
        .stallreq_o       (stallreq_o),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
        .predict_result_o (predict_result_o),
        .next_pc_o        (next_pc_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: "holding a word", "draining a dropped fetch", else fetching.
    bit          m_have;
    bit          m_drain;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_daddr;
    int          m_bht [64];

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (((v >> (bits - 1)) & 32'd1) != 32'd0) return v - (32'd1 << bits);
        return v;
    endfunction

    task automatic model_predict(output logic taken, output logic [31:0] npc);
        logic [31:0] imm;
        taken = 1'b0;
        npc   = m_pc + 32'd4;
        if ((m_inst & 32'h7f) == 32'h6f) begin
            imm = (((m_inst >> 31) & 32'h1) << 20) | (((m_inst >> 12) & 32'hff) << 12)
                | (((m_inst >> 20) & 32'h1) << 11) | (((m_inst >> 21) & 32'h3ff) << 1);
            taken = 1'b1;
            npc   = m_pc + sext(imm, 21);
        end else if ((m_inst & 32'h7f) == 32'h63 && m_bht[(m_pc >> 2) % 64] >= 2) begin
            imm = (((m_inst >> 31) & 32'h1) << 12) | (((m_inst >> 7) & 32'h1) << 11)
                | (((m_inst >> 25) & 32'h3f) << 5) | (((m_inst >> 8) & 32'hf) << 1);
            taken = 1'b1;
            npc   = m_pc + sext(imm, 13);
        end
    endtask

    task automatic check_outputs();
        logic        tk;
        logic [31:0] npc;
        if (rst) begin
            expect_eq("rst_req", {31'b0, mem_req_o}, 32'd0);
            expect_eq("rst_stallreq", {31'b0, stallreq_o}, 32'd0);
            expect_eq("rst_pc", pc_o, 32'd0);
            expect_eq("rst_inst", inst_o, 32'd0);
            expect_eq("rst_pred", {31'b0, predict_result_o}, 32'd0);
            expect_eq("rst_next", next_pc_o, 32'd0);
        end else if (m_have) begin
            model_predict(tk, npc);
            expect_eq("have_req", {31'b0, mem_req_o}, 32'd0);
            expect_eq("have_stallreq", {31'b0, stallreq_o}, 32'd0);
            expect_eq("have_pc", pc_o, m_pc);
            expect_eq("have_inst", inst_o, m_inst);
            expect_eq("have_pred", {31'b0, predict_result_o}, {31'b0, tk});
            expect_eq("have_next", next_pc_o, npc);
        end else begin
            expect_eq("fetch_req", {31'b0, mem_req_o}, 32'd1);
            expect_eq("fetch_addr", mem_addr_o, m_drain ? m_daddr : m_pc);
            expect_eq("fetch_stallreq", {31'b0, stallreq_o}, 32'd1);
            expect_eq("fetch_pc", pc_o, 32'd0);
            expect_eq("fetch_inst", inst_o, 32'd0);
            expect_eq("fetch_pred", {31'b0, predict_result_o}, 32'd0);
            expect_eq("fetch_next", next_pc_o, 32'd0);
        end
    endtask

    task automatic model_update();
        logic        tk;
        logic [31:0] npc;
        int          idx;
        if (rst) begin
            m_have  = 1'b0;
            m_drain = 1'b0;
            m_pc    = RstPc;
            foreach (m_bht[i]) m_bht[i] = 1;
        end else begin
            model_predict(tk, npc);
            if (m_drain) begin
                if (branch_error) m_pc = redirect_pc;
                if (mem_ready_i) m_drain = 1'b0;
            end else if (m_have) begin
                if (branch_error) begin
                    m_pc   = redirect_pc;
                    m_have = 1'b0;
                end else if (stall == Pass) begin
                    m_pc   = npc;
                    m_have = 1'b0;
                end
            end else begin
                if (branch_error) begin
                    if (!mem_ready_i) begin
                        m_drain = 1'b1;
                        m_daddr = m_pc;
                    end
                    m_pc = redirect_pc;
                end else if (mem_ready_i) begin
                    m_have = 1'b1;
                    m_inst = mem_inst_i;
                end
            end
            if (bht_we) begin
                idx = int'((bht_pc >> 2) % 64);
                if (bht_taken) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
                else           m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
            end
        end
    endtask

    // Inputs are set just after a posedge; outputs are sampled mid-cycle.
    task automatic tick();
        #2;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic fetch(input logic [31:0] word, input int waits);
        mem_ready_i = 1'b0;
        for (int i = 0; i < waits; i++) tick();
        mem_ready_i = 1'b1;
        mem_inst_i  = word;
        tick();
        mem_ready_i = 1'b0;
        mem_inst_i  = 32'h0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          kind;
        w    = $urandom;
        kind = $urandom_range(0, 3);
        if (kind == 0) w = (w & ~32'h7f) | 32'h13;
        else if (kind == 1) w = (w & ~32'h7f) | 32'h6f;
        else if (kind == 2) w = (w & ~32'h7f) | 32'h63;
        return w;
    endfunction

    initial begin
        int r;
        rst          = 1'b1;
        stall        = Pass;
        branch_error = 1'b0;
        redirect_pc  = 32'h0;
        bht_we       = 1'b0;
        bht_pc       = 32'h0;
        bht_taken    = 1'b0;
        mem_ready_i  = 1'b1;
        mem_inst_i   = 32'h00100093;
        tick();
        tick();

        // Zero-wait first fetch straight out of reset.
        rst = 1'b0;
        #1;
        expect_eq("first_addr", mem_addr_o, 32'h100);
        tick();
        mem_ready_i = 1'b0;
        expect_eq("first_pc", pc_o, 32'h100);
        expect_eq("first_inst", inst_o, 32'h00100093);
        tick();
        expect_eq("pass_to_req", {31'b0, mem_req_o}, 32'd1);
        expect_eq("pass_addr", mem_addr_o, 32'h104);

        // Straight-line code with a two-cycle memory.
        fetch(32'h00200113, 1);
        expect_eq("line_pc1", pc_o, 32'h104);
        expect_eq("line_next1", next_pc_o, 32'h108);
        tick();
        fetch(32'h00300193, 1);
        expect_eq("line_pc2", pc_o, 32'h108);
        expect_eq("line_pred2", {31'b0, predict_result_o}, 32'd0);
        tick();
        fetch(32'h00400213, 0);

        // Hold and Bubb keep the word; branch_error during Hold redirects.
        stall = Hold;
        tick();
        tick();
        tick();
        expect_eq("hold_req", {31'b0, mem_req_o}, 32'd0);
        expect_eq("hold_pc", pc_o, 32'h10C);
        stall = Bubb;
        tick();
        stall        = Hold;
        branch_error = 1'b1;
        redirect_pc  = 32'h100;
        tick();
        branch_error = 1'b0;
        stall        = Pass;
        expect_eq("hold_redirect", mem_addr_o, 32'h100);

        // JAL +0x20 at 0x100.
        fetch(32'h0200006F, 0);
        expect_eq("jal_pred", {31'b0, predict_result_o}, 32'd1);
        expect_eq("jal_next", next_pc_o, 32'h120);
        tick();
        expect_eq("jal_fetch", mem_addr_o, 32'h120);
        fetch(32'h00100093, 0);
        branch_error = 1'b1;
        redirect_pc  = 32'h200;
        tick();
        branch_error = 1'b0;

        // BEQ -8 at 0x200, before and after training the counter.
        fetch(32'hFE000CE3, 0);
        expect_eq("beq_cold_pred", {31'b0, predict_result_o}, 32'd0);
        expect_eq("beq_cold_next", next_pc_o, 32'h204);
        stall     = Hold;
        bht_we    = 1'b1;
        bht_pc    = 32'h200;
        bht_taken = 1'b1;
        tick();
        tick();
        bht_we = 1'b0;
        tick();
        expect_eq("beq_warm_pred", {31'b0, predict_result_o}, 32'd1);
        expect_eq("beq_warm_next", next_pc_o, 32'h1F8);
        stall = Pass;
        tick();

        // branch_error while a fetch waits: drain the old address first.
        branch_error = 1'b1;
        redirect_pc  = 32'h400;
        tick();
        branch_error = 1'b0;
        tick();
        expect_eq("drain_addr", mem_addr_o, 32'h1F8);
        expect_eq("drain_stallreq", {31'b0, stallreq_o}, 32'd1);
        mem_ready_i = 1'b1;
        mem_inst_i  = 32'h0200006F;
        tick();
        mem_ready_i = 1'b0;
        expect_eq("after_drain_addr", mem_addr_o, 32'h400);
        expect_eq("after_drain_inst", inst_o, 32'h0);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            rst          = ($urandom_range(0, 149) == 0);
            mem_ready_i  = $urandom_range(0, 1);
            mem_inst_i   = rand_inst();
            r            = $urandom_range(0, 9);
            stall        = (r < 6) ? Pass : (r < 8) ? Hold : Bubb;
            branch_error = ($urandom_range(0, 14) == 0);
            redirect_pc  = $urandom & 32'h0000_0FFC;
            bht_we       = ($urandom_range(0, 2) == 0);
            bht_pc       = $urandom & 32'h0000_0FFC;
            bht_taken    = $urandom_range(0, 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
